// File: rtl/clk_test_gen_pkg.sv
// Shared constants and request clamping for the test-clock generator.
package clk_test_gen_pkg;

    localparam int unsigned CNT_W_DEF = 26;
    localparam int unsigned CH_IDX_W  = 4;
    localparam int unsigned MAX_CH    = 16;
    localparam int unsigned CLAMP_W   = 32;

    typedef logic [CLAMP_W-1:0] clamp_t;

    // Period is at least two cycles so both a high and a low phase exist.
    function automatic clamp_t clamp_div(input clamp_t div);
        return (div < clamp_t'(2)) ? clamp_t'(2) : div;
    endfunction

    // High time of zero means "square-ish": half the (already clamped) period.
    function automatic clamp_t clamp_high(input clamp_t high, input clamp_t div_c);
        clamp_t res;
        if (high == '0) begin
            res = div_c >> 1;
        end else if (high >= div_c) begin
            res = div_c - clamp_t'(1);
        end else begin
            res = high;
        end
        return res;
    endfunction

endpackage

// File: rtl/clk_test_gen_if.sv
// Configuration request channel: target channel plus period/high-time payload.
interface clk_test_gen_if #(
    parameter int unsigned CNT_W = clk_test_gen_pkg::CNT_W_DEF
);
    logic                                   cfg_valid;
    logic                                   cfg_ready;
    logic [clk_test_gen_pkg::CH_IDX_W-1:0]  cfg_ch;
    logic [CNT_W-1:0]                       cfg_div;
    logic [CNT_W-1:0]                       cfg_high;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_high,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_high,
        output cfg_ready
    );
endinterface

// File: rtl/clk_test_gen_ch.sv
// One test-clock channel: divider counter, registered clock/tick and a
// shadowed configuration that is swapped in only at a period boundary.
module clk_test_ch
    import clk_test_gen_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned DEF_DIV  = 100,
    parameter int unsigned DEF_HIGH = 50
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic [CNT_W-1:0] wr_high,
    output logic             clk_out,
    output logic             period_tick,
    output logic             pending
);

    localparam logic [CNT_W-1:0] DEF_DIV_C  = CNT_W'(clamp_div(CLAMP_W'(DEF_DIV)));
    localparam logic [CNT_W-1:0] DEF_HIGH_C =
        CNT_W'(clamp_high(CLAMP_W'(DEF_HIGH), clamp_div(CLAMP_W'(DEF_DIV))));

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] high_act;
    logic [CNT_W-1:0] sh_div;
    logic [CNT_W-1:0] sh_high;
    logic             at_wrap;

    always_comb begin
        at_wrap = (cnt == (div_act - CNT_W'(1)));
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt         <= '0;
            clk_out     <= 1'b0;
            period_tick <= 1'b0;
            pending     <= 1'b0;
            div_act     <= DEF_DIV_C;
            high_act    <= DEF_HIGH_C;
            sh_div      <= DEF_DIV_C;
            sh_high     <= DEF_HIGH_C;
        end else begin
            // Output reflects the count entering this edge, so re-enable rises at once.
            clk_out     <= en && (cnt < high_act);
            period_tick <= en && at_wrap;

            if (!en || at_wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            // Swap uses the pending flag from before this edge, so a request
            // landing on a wrap waits for the next one.
            if (pending && (!en || at_wrap)) begin
                div_act  <= sh_div;
                high_act <= sh_high;
                pending  <= 1'b0;
            end else if (wr) begin
                sh_div   <= CNT_W'(clamp_div(CLAMP_W'(wr_div)));
                sh_high  <= CNT_W'(clamp_high(CLAMP_W'(wr_high), clamp_div(CLAMP_W'(wr_div))));
                pending  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_test_gen.sv
// Multi-channel programmable test-clock generator: request decode plus one
// independent divider channel per output bit.
module clk_test_gen
    import clk_test_gen_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned DEF_DIV  = 100,
    parameter int unsigned DEF_HIGH = 50
) (
    input  logic            clk_in,
    input  logic            rst,
    input  logic [N_CH-1:0] ch_en,
    clk_test_gen_if.slave   cfg,
    output logic [N_CH-1:0] clk_out,
    output logic [N_CH-1:0] period_tick
);

    logic [N_CH-1:0]   pending;
    logic [N_CH-1:0]   wr;
    logic [MAX_CH-1:0] pend_ext;
    logic              accept;

    // Unimplemented channel indices read as never-pending, so they are accepted and dropped.
    always_comb begin
        pend_ext      = MAX_CH'(pending);
        cfg.cfg_ready = !rst && !pend_ext[cfg.cfg_ch];
    end

    always_comb begin
        accept = cfg.cfg_valid && !rst && !pend_ext[cfg.cfg_ch];
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign wr[i] = accept && (cfg.cfg_ch == CH_IDX_W'(i));

        clk_test_ch #(
            .CNT_W    (CNT_W),
            .DEF_DIV  (DEF_DIV),
            .DEF_HIGH (DEF_HIGH)
        ) u_ch (
            .clk_in      (clk_in),
            .rst         (rst),
            .en          (ch_en[i]),
            .wr          (wr[i]),
            .wr_div      (cfg.cfg_div),
            .wr_high     (cfg.cfg_high),
            .clk_out     (clk_out[i]),
            .period_tick (period_tick[i]),
            .pending     (pending[i])
        );
    end

endmodule

// File: tb/tb_clk_test_gen.sv
// Directed bench for clk_test_gen: reset, default run, odd/clamped divides,
// wrap collision, disable and reset-with-pending corner cases.
module tb_clk_test_gen;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned CNT_W = 26;

    logic            clk_in = 1'b0;
    logic            rst;
    logic [N_CH-1:0] ch_en;
    logic [N_CH-1:0] clk_out;
    logic [N_CH-1:0] period_tick;

    clk_test_gen_if #(.CNT_W(CNT_W)) cfg_if ();

    clk_test_gen #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .DEF_DIV  (100),
        .DEF_HIGH (50)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .ch_en       (ch_en),
        .cfg         (cfg_if),
        .clk_out     (clk_out),
        .period_tick (period_tick)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int ch;
        int div;
        int high;
        int exp_hi;
        int exp_lo;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic set_ch(input int ch);
        cfg_if.cfg_ch = 4'(ch);
        #1;
    endtask

    // Length of the next complete high run and the low run that follows it.
    task automatic measure(input int ch, output int hi, output int lo);
        int guard;
        guard = 0;
        hi    = 0;
        lo    = 0;
        while (!clk_out[ch] && guard < 1000) begin guard++; step(1); end
        while (clk_out[ch] && hi < 1000)     begin hi++;    step(1); end
        while (!clk_out[ch] && lo < 1000)    begin lo++;    step(1); end
    endtask

    task automatic wait_ready(input int budget);
        int waited;
        waited = 0;
        while (!cfg_if.cfg_ready && waited < budget) begin waited++; step(1); end
    endtask

    task automatic send(input int ch, input int div, input int high);
        set_ch(ch);
        cfg_if.cfg_div   = CNT_W'(div);
        cfg_if.cfg_high  = CNT_W'(high);
        cfg_if.cfg_valid = 1'b1;
        step(1);
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        int hi, lo, n, g, ones, ticks, hi1;

        tbl[0] = '{ch: 1, div: 7,  high: 0,  exp_hi: 3, exp_lo: 4};
        tbl[1] = '{ch: 0, div: 10, high: 3,  exp_hi: 3, exp_lo: 7};
        tbl[2] = '{ch: 3, div: 5,  high: 5,  exp_hi: 4, exp_lo: 1};
        tbl[3] = '{ch: 2, div: 0,  high: 0,  exp_hi: 1, exp_lo: 1};
        tbl[4] = '{ch: 1, div: 9,  high: 20, exp_hi: 8, exp_lo: 1};
        tbl[5] = '{ch: 0, div: 2,  high: 1,  exp_hi: 1, exp_lo: 1};
        tbl[6] = '{ch: 2, div: 3,  high: 0,  exp_hi: 1, exp_lo: 2};
        tbl[7] = '{ch: 3, div: 13, high: 6,  exp_hi: 6, exp_lo: 7};

        rst              = 1'b1;
        ch_en            = '0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_high  = '0;

        // Reset values
        step(3);
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_tick", int'(period_tick), 0);
        check("rst_ready", int'(cfg_if.cfg_ready), 0);
        rst = 1'b0;
        step(2);
        check("dis_clk_out", int'(clk_out), 0);
        check("idle_ready", int'(cfg_if.cfg_ready), 1);

        // Default run: rises on the first enabled edge, 50/50, tick every 100
        ch_en = '1;
        step(1);
        check("en_rise", int'(clk_out), 15);
        measure(0, hi, lo);
        check("def_hi", hi, 50);
        check("def_lo", lo, 50);
        g = 0;
        while (!period_tick[0] && g < 200) begin g++; step(1); end
        step(1);
        n = 1;
        while (!period_tick[0] && n < 300) begin n++; step(1); end
        check("tick_spacing", n, 100);

        // Wrap collision on ch2: request lands in the cnt=99 cycle
        g = 0;
        while (!period_tick[2] && g < 200) begin g++; step(1); end
        step(99);
        set_ch(2);
        check("coll_ready_before", int'(cfg_if.cfg_ready), 1);
        cfg_if.cfg_div   = CNT_W'(6);
        cfg_if.cfg_high  = CNT_W'(2);
        cfg_if.cfg_valid = 1'b1;
        step(1);
        cfg_if.cfg_div  = CNT_W'(8);
        cfg_if.cfg_high = CNT_W'(3);
        n = 0;
        while (!cfg_if.cfg_ready && n < 300) begin n++; step(1); end
        check("coll_stall", n, 100);
        step(1);
        cfg_if.cfg_valid = 1'b0;
        measure(2, hi, lo);
        check("coll_new_hi", hi, 2);
        check("coll_new_lo", lo, 4);
        measure(2, hi, lo);
        check("coll_second_hi", hi, 3);
        check("coll_second_lo", lo, 5);

        // Mid-period update on ch3 must not truncate the running period
        set_ch(3);
        cfg_if.cfg_div  = CNT_W'(1);
        cfg_if.cfg_high = CNT_W'(9);
        g = 0;
        while (clk_out[3] && g < 200)  begin g++; step(1); end
        while (!clk_out[3] && g < 400) begin g++; step(1); end
        hi = 0;
        while (clk_out[3] && hi < 1000) begin
            cfg_if.cfg_valid = (hi == 20);
            hi++;
            step(1);
        end
        cfg_if.cfg_valid = 1'b0;
        lo = 0;
        while (!clk_out[3] && lo < 1000) begin lo++; step(1); end
        check("mid_old_hi", hi, 50);
        check("mid_old_lo", lo, 50);
        measure(3, hi, lo);
        check("clamp_hi", hi, 1);
        check("clamp_lo", lo, 1);

        // Reset at cnt=30 on ch1 with an update pending
        g = 0;
        while (!period_tick[1] && g < 200) begin g++; step(1); end
        send(1, 4, 2);
        step(29);
        check("pend_before_rst", int'(cfg_if.cfg_ready), 0);
        rst = 1'b1;
        step(1);
        check("rst2_clk_out", int'(clk_out), 0);
        check("rst2_tick", int'(period_tick), 0);
        check("rst2_ready", int'(cfg_if.cfg_ready), 0);
        step(1);
        rst = 1'b0;
        step(1);
        check("post_rst_rise", int'(clk_out), 15);
        check("post_rst_ready", int'(cfg_if.cfg_ready), 1);
        measure(1, hi, lo);
        check("post_rst_hi", hi, 50);
        check("post_rst_lo", lo, 50);

        // Disable ch0 mid-high; a pending update applies while disabled
        step(10);
        ch_en[0] = 1'b0;
        step(1);
        check("drop_low", int'(clk_out[0]), 0);
        send(0, 4, 1);
        check("dis_pend", int'(cfg_if.cfg_ready), 0);
        step(1);
        check("dis_apply", int'(cfg_if.cfg_ready), 1);
        ones  = 0;
        ticks = 0;
        hi1   = 0;
        repeat (120) begin
            ones  += int'(clk_out[0]);
            ticks += int'(period_tick[0]);
            hi1   += int'(clk_out[1]);
            step(1);
        end
        check("dis_clk_quiet", ones, 0);
        check("dis_tick_quiet", ticks, 0);
        check("other_ch_runs", int'(hi1 >= 50), 1);
        ch_en[0] = 1'b1;
        step(1);
        check("reen_rise", int'(clk_out[0]), 1);
        measure(0, hi, lo);
        check("reen_hi", hi, 1);
        check("reen_lo", lo, 3);

        // Out-of-range channel: accepted, no state change
        set_ch(15);
        check("bad_ch_ready", int'(cfg_if.cfg_ready), 1);
        send(15, 2, 1);
        for (int c = 0; c < int'(N_CH); c++) begin
            set_ch(c);
            check($sformatf("bad_ch_no_pend%0d", c), int'(cfg_if.cfg_ready), 1);
        end
        measure(0, hi, lo);
        check("bad_ch_hi", hi, 1);
        check("bad_ch_lo", lo, 3);

        // Table of clamped/odd configurations
        for (int i = 0; i < 8; i++) begin
            set_ch(tbl[i].ch);
            wait_ready(300);
            send(tbl[i].ch, tbl[i].div, tbl[i].high);
            wait_ready(300);
            check($sformatf("tbl%0d_apply", i), int'(cfg_if.cfg_ready), 1);
            measure(tbl[i].ch, hi, lo);
            check($sformatf("tbl%0d_hi", i), hi, tbl[i].exp_hi);
            check($sformatf("tbl%0d_lo", i), lo, tbl[i].exp_lo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_test_gen.md
CLK_TEST_GEN -- requirements
Module: clk_test_gen

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent test-clock channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 26: width of divide and high-time values.
REQ-003 SHALL have parameter DEF_DIV, default 100: divide ratio loaded at reset.
REQ-004 SHALL have parameter DEF_HIGH, default 50: high-time, in clk_in cycles, loaded at reset.
REQ-005 SHALL have port clk_in  input  1  the single clock. All logic is on the rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port ch_en  input  N_CH  per-channel run enable.
REQ-008 SHALL have port cfg_valid  input  1  configuration request.
REQ-009 SHALL have port cfg_ready  output  1  the request can be accepted.
REQ-010 SHALL have port cfg_ch  input  4  target channel.
REQ-011 SHALL have port cfg_div  input  CNT_W  requested period, in clk_in cycles.
REQ-012 SHALL have port cfg_high  input  CNT_W  requested high time, in clk_in cycles.
REQ-013 SHALL have port clk_out  output  N_CH  generated test clocks. Each bit is registered.
REQ-014 SHALL have port period_tick  output  N_CH  one-cycle pulse per completed period.

Function
REQ-015 Each channel SHALL hold active values div_act and high_act, a counter cnt (0..div_act-1), a pending flag and shadow values.
REQ-016 While ch_en[i]=1:
- cnt SHALL increment every cycle.
- cnt SHALL wrap to 0 after div_act-1.
REQ-017 clk_out[i] SHALL equal (cnt < high_act), registered.
- The period SHALL be exactly div_act cycles, with high_act cycles high.
- Odd ratios SHALL be supported.
REQ-018 period_tick[i] SHALL pulse for one cycle on the cycle following the wrap from div_act-1 to 0.
REQ-019 While ch_en[i]=0:
- cnt SHALL be held at 0.
- clk_out[i] SHALL be 0 and period_tick[i] SHALL be 0.
- On re-enable, clk_out[i] SHALL rise on the first edge at which ch_en[i] is sampled high.
REQ-020 A request SHALL be accepted when cfg_valid & cfg_ready.
- On acceptance, the clamped values SHALL be written to the shadow of cfg_ch and pending SHALL be set.
REQ-021 cfg_ready SHALL be 0 while pending[cfg_ch]=1 or rst=1. Otherwise it SHALL be 1. cfg_ready is combinational on cfg_ch.
REQ-022 A pending update SHALL be applied on the cycle in which cnt=div_act-1 (the wrap), or on the next cycle if the channel is disabled.
- On application, pending SHALL be cleared and the new period SHALL start at cnt=0.
- There SHALL be no glitch and no truncated period.
REQ-023 If acceptance coincides with a wrap on the same channel, the update SHALL apply at the following wrap.
REQ-024 Clamping of requested values:
- cfg_div<2 SHALL be treated as 2.
- cfg_high=0 SHALL be treated as floor(div/2).
- cfg_high>=div SHALL be treated as div-1.
REQ-025 A request with cfg_ch>=N_CH SHALL be accepted and discarded, with no state change.
REQ-026 Channels SHALL be fully independent. Simultaneous wraps and updates on different channels SHALL NOT interact.

Reset
REQ-027 While rst=1, the following SHALL hold:
- cnt=0, clk_out=0, period_tick=0, pending=0.
- div_act=DEF_DIV and high_act=DEF_HIGH, clamped per REQ-024.
REQ-028 A rst assertion mid-period or while an update is pending SHALL discard the pending update. The first period after reset SHALL be complete.

Structure
REQ-029 A shared package SHALL hold the CNT_W default, the clamp function and the channel-index width.
REQ-030 A sub-module clk_test_ch SHALL implement one channel (REQ-015..019, 022..024). The top SHALL generate N_CH instances plus the cfg decode.

Verification
REQ-031 Default run: reset, then ch_en=1 -> clk_out[0] gives 50 cycles high / 50 cycles low, and period_tick repeats every 100 cycles.
REQ-032 Odd divide: cfg div=7, high=0 on ch1 -> after the next wrap, 3 cycles high / 4 cycles low. cfg_ready is 0 until applied.
REQ-033 Clamping: div=1, high=9 -> div=2, high=1 gives a 1-high/1-low square wave. An update mid-period does not truncate the current period.
REQ-034 Wrap collision: accept a request on ch2 in its cnt=99 cycle -> the old period repeats once more, then the new values apply. A second request on ch2 stalls until then.
REQ-035 Reset/disable: assert rst at cnt=30 with an update pending -> all outputs are 0 and the update is lost. Drop ch_en mid-high -> clk_out goes 0 next cycle. A cfg_ch=15 request changes nothing.
